// File: rtl/fsm_moore_timed_pkg.sv
// Shared types for the timed Moore handshake controller: one-hot state
// encoding, the packed control-output bundle and its state decode.
package fsm_moore_timed_pkg;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_ST   = 5'b00010,
    S_HD   = 5'b00100,
    S_DT   = 5'b01000,
    S_ERR  = 5'b10000
  } state_t;

  typedef struct packed {
    logic reset;
    logic start;
    logic y;
    logic busy;
    logic err;
  } ctrl_t;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic ctrl_t decode(input state_t s);
    ctrl_t o;
    o       = '0;
    o.reset = 1'b1;
    case (s)
      S_IDLE: begin
        o.reset = 1'b1;
      end
      S_ST: begin
        o.reset = 1'b0;
        o.start = 1'b1;
        o.busy  = 1'b1;
      end
      S_HD: begin
        o.reset = 1'b0;
        o.busy  = 1'b1;
      end
      S_DT: begin
        o.reset = 1'b0;
        o.y     = 1'b1;
        o.busy  = 1'b1;
      end
      S_ERR: begin
        o.reset = 1'b1;
        o.err   = 1'b1;
      end
      default: begin
        o.reset = 1'b1;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/fsm_moore_timed_cnt.sv
// Clear/enable saturating up-counter with a terminal-count compare output.
// Clear has priority over enable; the count holds at all-ones.
module fsm_moore_timed_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_i);

endmodule

// File: rtl/fsm_moore_timed.sv
// Timed Moore controller: RESET/START/wait-READY/data phases with START width,
// READY timeout, bounded retry and sticky error. Optional FSM_MOORE_TIMED_REG_OUT_EN.
module fsm_moore_timed
  import fsm_moore_timed_pkg::*;
#(
  parameter  int unsigned START_LEN = 2,
  parameter  int unsigned TIMEOUT   = 8,
  parameter  int unsigned MAX_RETRY = 2,
  localparam int unsigned RW        = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1)
) (
  input  logic          CLK,
  input  logic          N_RESET,
  input  logic          X,
  input  logic          READY,
  output logic          RESET,
  output logic          START,
  output logic          Y,
  output logic          BUSY,
  output logic          ERR,
  output logic [RW-1:0] RETRY_CNT
);

  localparam int unsigned TW = cnt_width(max2(START_LEN, TIMEOUT));
  localparam logic [TW-1:0] ST_TC     = TW'(START_LEN - 1);
  localparam logic [TW-1:0] HD_TC     = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_t        state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          tmr_clr, tmr_en, tmr_tc;
  logic [TW-1:0] tmr_cnt, tmr_lim;
  ctrl_t         ctrl;

  assign tmr_lim = (state_q == S_ST) ? ST_TC : HD_TC;

  fsm_moore_timed_cnt #(
    .W (TW)
  ) u_timer (
    .clk_i  (CLK),
    .rst_ni (N_RESET),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .tc_i   (tmr_lim),
    .cnt_o  (tmr_cnt),
    .tc_o   (tmr_tc)
  );

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q <= S_IDLE;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_clr = 1'b1;
        retry_d = '0;
        if (X) state_d = S_ST;
      end
      S_ST: begin
        if (!X) begin
          state_d = S_IDLE;
          retry_d = '0;
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          state_d = S_HD;
          tmr_clr = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_HD: begin
        // READY is tested before expiry so a late READY still completes.
        if (!X) begin
          state_d = S_IDLE;
          retry_d = '0;
          tmr_clr = 1'b1;
        end else if (READY) begin
          state_d = S_DT;
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          tmr_clr = 1'b1;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = S_ST;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_DT, S_ERR: begin
        if (!X) begin
          state_d = S_IDLE;
          retry_d = '0;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        retry_d = '0;
        tmr_clr = 1'b1;
      end
    endcase
  end

`ifdef FSM_MOORE_TIMED_REG_OUT_EN
  // Registering decode(state_d) reproduces decode(state_q) on the same cycle.
  ctrl_t ctrl_q;

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      ctrl_q <= decode(S_IDLE);
    end else begin
      ctrl_q <= decode(state_d);
    end
  end

  always_comb begin
    ctrl = ctrl_q;
  end
`else
  always_comb begin
    ctrl = decode(state_q);
  end
`endif

  assign RESET     = ctrl.reset;
  assign START     = ctrl.start;
  assign Y         = ctrl.y;
  assign BUSY      = ctrl.busy;
  assign ERR       = ctrl.err;
  assign RETRY_CNT = retry_q;

endmodule

// File: tb/tb_fsm_moore_timed.sv
// Directed bench for fsm_moore_timed: vector table plus hand-written
// multi-cycle sequences; a second instance covers the minimal parameter set.
module tb_fsm_moore_timed;

  localparam logic [4:0] O_IDLE = 5'b10000;
  localparam logic [4:0] O_ST   = 5'b01010;
  localparam logic [4:0] O_HD   = 5'b00010;
  localparam logic [4:0] O_DT   = 5'b00110;
  localparam logic [4:0] O_ERR  = 5'b10001;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       N_RESET, X, READY;
  logic       RESET, START, Y, BUSY, ERR;
  logic [1:0] RETRY_CNT;

  logic       X2, READY2;
  logic       RESET2, START2, Y2, BUSY2, ERR2;
  logic [0:0] RETRY_CNT2;

  int checks   = 0;
  int failures = 0;

  fsm_moore_timed dut (
    .CLK       (CLK),
    .N_RESET   (N_RESET),
    .X         (X),
    .READY     (READY),
    .RESET     (RESET),
    .START     (START),
    .Y         (Y),
    .BUSY      (BUSY),
    .ERR       (ERR),
    .RETRY_CNT (RETRY_CNT)
  );

  fsm_moore_timed #(
    .START_LEN (1),
    .TIMEOUT   (1),
    .MAX_RETRY (0)
  ) dut_min (
    .CLK       (CLK),
    .N_RESET   (N_RESET),
    .X         (X2),
    .READY     (READY2),
    .RESET     (RESET2),
    .START     (START2),
    .Y         (Y2),
    .BUSY      (BUSY2),
    .ERR       (ERR2),
    .RETRY_CNT (RETRY_CNT2)
  );

  typedef struct {
    logic       x;
    logic       ready;
    logic [4:0] exp_o;
    logic [1:0] exp_r;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [4:0] eo, input logic [1:0] er);
    logic [4:0] got;
    got = {RESET, START, Y, BUSY, ERR};
    checks++;
    if (got !== eo || RETRY_CNT !== er) begin
      failures++;
      $display("FAIL %s: got outputs=%b retry=%0d, expected outputs=%b retry=%0d",
               nm, got, RETRY_CNT, eo, er);
    end
  endtask

  task automatic chk2(input string nm, input logic [4:0] eo);
    logic [4:0] got;
    got = {RESET2, START2, Y2, BUSY2, ERR2};
    checks++;
    if (got !== eo || RETRY_CNT2 !== 1'b0) begin
      failures++;
      $display("FAIL %s: got outputs=%b retry=%0d, expected outputs=%b retry=0",
               nm, got, RETRY_CNT2, eo);
    end
  endtask

  task automatic step(input logic x, input logic r);
    X     = x;
    READY = r;
    @(posedge CLK);
    #1;
  endtask

  task automatic step2(input logic x, input logic r);
    X2     = x;
    READY2 = r;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    N_RESET = 1'b0;
    X       = 1'b0;
    READY   = 1'b0;
    X2      = 1'b0;
    READY2  = 1'b0;
    #1;
    chk("reset_values", O_IDLE, 2'd0);
    chk2("min_reset_values", O_IDLE);
    #11 N_RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("idle_after_reset", O_IDLE, 2'd0);

    // Normal handshake: READY during ST is ignored, READY on 3rd HD cycle.
    tbl[0] = '{x: 1'b1, ready: 1'b0, exp_o: O_ST,   exp_r: 2'd0};
    tbl[1] = '{x: 1'b1, ready: 1'b1, exp_o: O_ST,   exp_r: 2'd0};
    tbl[2] = '{x: 1'b1, ready: 1'b1, exp_o: O_HD,   exp_r: 2'd0};
    tbl[3] = '{x: 1'b1, ready: 1'b0, exp_o: O_HD,   exp_r: 2'd0};
    tbl[4] = '{x: 1'b1, ready: 1'b0, exp_o: O_HD,   exp_r: 2'd0};
    tbl[5] = '{x: 1'b1, ready: 1'b1, exp_o: O_DT,   exp_r: 2'd0};
    tbl[6] = '{x: 1'b1, ready: 1'b0, exp_o: O_DT,   exp_r: 2'd0};
    tbl[7] = '{x: 1'b1, ready: 1'b1, exp_o: O_DT,   exp_r: 2'd0};
    tbl[8] = '{x: 1'b0, ready: 1'b0, exp_o: O_IDLE, exp_r: 2'd0};
    tbl[9] = '{x: 1'b0, ready: 1'b1, exp_o: O_IDLE, exp_r: 2'd0};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].x, tbl[i].ready);
      chk($sformatf("vec%0d", i), tbl[i].exp_o, tbl[i].exp_r);
    end

    // READY never arrives: three attempts of 2 ST + 8 HD cycles, then ERR.
    for (int c = 0; c < 30; c++) begin
      step(1'b1, 1'b0);
      chk($sformatf("retry_c%0d", c), ((c % 10) < 2) ? O_ST : O_HD, 2'(c / 10));
    end
    step(1'b1, 1'b0);
    chk("err_entry", O_ERR, 2'd2);
    step(1'b1, 1'b1);
    chk("err_sticky", O_ERR, 2'd2);
    step(1'b1, 1'b0);
    chk("err_sticky2", O_ERR, 2'd2);
    step(1'b0, 1'b0);
    chk("err_exit", O_IDLE, 2'd0);

    // READY exactly on the expiry cycle of the first attempt.
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b0);
      chk($sformatf("expiry_c%0d", c), (c < 2) ? O_ST : O_HD, 2'd0);
    end
    step(1'b1, 1'b1);
    chk("expiry_ready_dt", O_DT, 2'd0);
    step(1'b1, 1'b0);
    chk("expiry_dt_hold", O_DT, 2'd0);
    step(1'b0, 1'b0);
    chk("dt_abort", O_IDLE, 2'd0);

    // Abort mid-ST.
    step(1'b1, 1'b0);
    chk("st_enter", O_ST, 2'd0);
    step(1'b0, 1'b0);
    chk("st_abort", O_IDLE, 2'd0);

    // Abort in HD after one retry.
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("retry1_st", O_ST, 2'd1);
    step(1'b1, 1'b0);
    chk("retry1_st2", O_ST, 2'd1);
    step(1'b1, 1'b0);
    chk("retry1_hd", O_HD, 2'd1);
    step(1'b0, 1'b1);
    chk("hd_abort", O_IDLE, 2'd0);

    // Asynchronous reset between edges while in DT.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("pre_reset_hd", O_HD, 2'd0);
    step(1'b1, 1'b1);
    chk("pre_reset_dt", O_DT, 2'd0);
    #3 N_RESET = 1'b0;
    #1;
    chk("async_reset_dt", O_IDLE, 2'd0);
    #2 N_RESET = 1'b1;
    step(1'b1, 1'b0);
    chk("restart_after_reset", O_ST, 2'd0);
    step(1'b0, 1'b0);
    chk("idle_after_restart", O_IDLE, 2'd0);

    // Minimal parameters: one ST cycle, one HD cycle, no retry.
    step2(1'b1, 1'b0);
    chk2("min_st", O_ST);
    step2(1'b1, 1'b0);
    chk2("min_hd", O_HD);
    step2(1'b1, 1'b0);
    chk2("min_err", O_ERR);
    step2(1'b1, 1'b1);
    chk2("min_err_sticky", O_ERR);
    step2(1'b0, 1'b0);
    chk2("min_idle", O_IDLE);
    step2(1'b1, 1'b1);
    chk2("min_st_b", O_ST);
    step2(1'b1, 1'b1);
    chk2("min_hd_b", O_HD);
    step2(1'b1, 1'b1);
    chk2("min_dt_on_expiry", O_DT);
    step2(1'b0, 1'b0);
    chk2("min_idle_b", O_IDLE);
    chk("main_idle_during_min", O_IDLE, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
